// File: rtl/i2s_tx_master.sv
// I2S transmit master: mclk-derived bit clock, 64-slot frames, one-pair holding buffer.
// Build macro I2S_TX_UNDERRUN_REPEAT_EN: on underrun replay the last loaded pair instead of silence.
module i2s_tx_master #(
  parameter int DATA_RES  = 24,
  parameter int SCLK_HALF = 4
) (
  input  logic                mclk,
  input  logic                reset_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_RES-1:0] s_left,
  input  logic [DATA_RES-1:0] s_right,
  input  logic                underrun_clr,
  output logic                sclk,
  output logic                lrclk,
  output logic                sdout,
  output logic                frame_start,
  output logic                underrun
);

  localparam logic [7:0] HALF_LAST      = 8'(SCLK_HALF - 1);
  localparam logic [4:0] DATA_LAST_SLOT = 5'(DATA_RES);

  logic [7:0]          div_r;
  logic                sclk_r;
  logic                lrclk_r;
  logic                sdout_r;
  logic                frame_start_r;
  logic                underrun_r;
  logic [5:0]          slot_r;
  logic                buf_full_r;
  logic [DATA_RES-1:0] buf_l_r;
  logic [DATA_RES-1:0] buf_r_r;
  logic [DATA_RES-1:0] sh_l_r;
  logic [DATA_RES-1:0] sh_r_r;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  logic [DATA_RES-1:0] last_l_r;
  logic [DATA_RES-1:0] last_r_r;
`endif

  logic                tick_s;
  logic                fall_s;
  logic                wrap_s;
  logic                accept_s;
  logic [5:0]          slot_nxt_s;
  logic [4:0]          ch_slot_s;
  logic                data_slot_s;
  logic [DATA_RES-1:0] load_l_s;
  logic [DATA_RES-1:0] load_r_s;

  // Divider tick, slot decode, handshake and frame-load source selection.
  always_comb begin
    tick_s      = (div_r == HALF_LAST);
    fall_s      = tick_s & sclk_r;
    slot_nxt_s  = slot_r + 6'd1;
    wrap_s      = fall_s & (slot_r == 6'd63);
    accept_s    = s_valid & ~buf_full_r;
    ch_slot_s   = slot_nxt_s[4:0];
    data_slot_s = (ch_slot_s != 5'd0) && (ch_slot_s <= DATA_LAST_SLOT);
    if (buf_full_r) begin
      load_l_s = buf_l_r;
      load_r_s = buf_r_r;
    end else begin
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
      load_l_s = last_l_r;
      load_r_s = last_r_r;
`else
      load_l_s = {DATA_RES{1'b0}};
      load_r_s = {DATA_RES{1'b0}};
`endif
    end
  end

  // Bit-clock divider: sclk toggles every SCLK_HALF mclk cycles, idling high.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      div_r  <= 8'd0;
      sclk_r <= 1'b1;
    end else if (tick_s) begin
      div_r  <= 8'd0;
      sclk_r <= ~sclk_r;
    end else begin
      div_r  <= div_r + 8'd1;
    end
  end

  // Slot counter, word select and serial data all move only on sclk falling edges.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      slot_r  <= 6'd63;
      lrclk_r <= 1'b1;
      sdout_r <= 1'b0;
      sh_l_r  <= {DATA_RES{1'b0}};
      sh_r_r  <= {DATA_RES{1'b0}};
    end else if (fall_s) begin
      slot_r  <= slot_nxt_s;
      lrclk_r <= slot_nxt_s[5];
      if (wrap_s) begin
        sh_l_r  <= load_l_s;
        sh_r_r  <= load_r_s;
        sdout_r <= 1'b0;
      end else if (data_slot_s && slot_nxt_s[5]) begin
        sdout_r <= sh_r_r[DATA_RES-1];
        sh_r_r  <= sh_r_r << 1'b1;
      end else if (data_slot_s) begin
        sdout_r <= sh_l_r[DATA_RES-1];
        sh_l_r  <= sh_l_r << 1'b1;
      end else begin
        sdout_r <= 1'b0;
      end
    end else begin
      slot_r  <= slot_r;
    end
  end

  // Frame-load strobe.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= wrap_s;
    end
  end

  // Holding buffer: a frame load empties it before any new pair can be accepted.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      buf_full_r <= 1'b0;
      buf_l_r    <= {DATA_RES{1'b0}};
      buf_r_r    <= {DATA_RES{1'b0}};
    end else if (wrap_s && buf_full_r) begin
      buf_full_r <= 1'b0;
    end else if (accept_s) begin
      buf_full_r <= 1'b1;
      buf_l_r    <= s_left;
      buf_r_r    <= s_right;
    end else begin
      buf_full_r <= buf_full_r;
    end
  end

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  // Remember the last pair that was really loaded, for replay on underrun.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      last_l_r <= {DATA_RES{1'b0}};
      last_r_r <= {DATA_RES{1'b0}};
    end else if (wrap_s && buf_full_r) begin
      last_l_r <= buf_l_r;
      last_r_r <= buf_r_r;
    end else begin
      last_l_r <= last_l_r;
    end
  end
`endif

  // Sticky underrun flag; a new underrun takes priority over a clear request.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      underrun_r <= 1'b0;
    end else if (wrap_s && !buf_full_r) begin
      underrun_r <= 1'b1;
    end else if (underrun_clr) begin
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= underrun_r;
    end
  end

  assign s_ready     = ~buf_full_r;
  assign sclk        = sclk_r;
  assign lrclk       = lrclk_r;
  assign sdout       = sdout_r;
  assign frame_start = frame_start_r;
  assign underrun    = underrun_r;

endmodule

// File: tb/tb_i2s_tx_master.sv
// Scoreboard bench for i2s_tx_master: expected frames queued at issue time, checked by a frame monitor.
module tb_i2s_tx_master;

  localparam int DR   = 24;
  localparam int HALF = 4;

  typedef struct packed {
    logic [23:0] l;
    logic [23:0] r;
  } pair_t;

  logic          mclk         = 1'b0;
  logic          reset_n      = 1'b0;
  logic          s_valid      = 1'b0;
  logic          underrun_clr = 1'b0;
  logic [DR-1:0] s_left       = 24'd0;
  logic [DR-1:0] s_right      = 24'd0;
  logic          s_ready, sclk, lrclk, sdout, frame_start, underrun;

  pair_t exp_q[$];
  pair_t fill;
  int    n_cmp = 0;
  int    n_err = 0;

  always #5 mclk = ~mclk;

  i2s_tx_master #(.DATA_RES(DR), .SCLK_HALF(HALF)) dut (
    .mclk(mclk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_left(s_left), .s_right(s_right), .underrun_clr(underrun_clr),
    .sclk(sclk), .lrclk(lrclk), .sdout(sdout),
    .frame_start(frame_start), .underrun(underrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offer one pair and hold it until accepted; returns at the negedge after the transfer.
  task automatic push_pair(input logic [23:0] l, input logic [23:0] r);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_left  = l;
    s_right = r;
    for (int i = 0; i < 2000; i++) begin
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge mclk);
    end
    if (ok) @(negedge mclk);
    check("push_accepted", {31'd0, ok}, 32'd1);
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_left  = 24'hDEADBE;
    s_right = 24'hBEEFED;
  endtask

  task automatic wait_boundary(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge mclk);
      if (frame_start) begin
        seen = 1'b1;
        break;
      end
    end
    check({"boundary_", tag}, {31'd0, seen}, 32'd1);
  endtask

  // Frame monitor: capture sdout on sclk rising edges, compare each completed frame.
  logic [31:0] cap_l, cap_r;
  logic        lr_bad, sclk_p, lr_p, sd_p;
  int          idx, since_chg, since_fs, tim_bad;
  bit          active, fs_seen;
  pair_t       e;

  initial begin
    tim_bad = 0;
    forever begin
      @(negedge mclk);
      if (!reset_n) begin
        active = 1'b0; fs_seen = 1'b0; idx = 0; since_chg = 0; since_fs = 0;
      end else begin
        since_chg++;
        since_fs++;
        if (sclk != sclk_p) begin
          if (since_chg != HALF) tim_bad++;
          since_chg = 0;
        end
        if ((sdout != sd_p || lrclk != lr_p) && !(sclk_p && !sclk)) tim_bad++;
        if (active && sclk && !sclk_p) begin
          if (idx < 32) cap_l[31-idx] = sdout;
          else if (idx < 64) cap_r[63-idx] = sdout;
          if (idx < 64 && lrclk != (idx >= 32)) lr_bad = 1'b1;
          idx++;
        end
        if (frame_start) begin
          if (fs_seen) check("frame_period", since_fs, 32'd512);
          fs_seen  = 1'b1;
          since_fs = 0;
          if (active) begin
            check("slot_count", idx, 32'd64);
            check("lrclk_pattern", {31'd0, lr_bad}, 32'd0);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("left_word",  cap_l, {1'b0, e.l, 7'd0});
              check("right_word", cap_r, {1'b0, e.r, 7'd0});
            end else begin
              n_cmp++;
              n_err++;
              $display("FAIL unexpected_frame: got frame L=0x%0h R=0x%0h, expected none", cap_l, cap_r);
            end
          end
          active = 1'b1; idx = 0; lr_bad = 1'b0; cap_l = 32'd0; cap_r = 32'd0;
        end
      end
      sclk_p = sclk;
      lr_p   = lrclk;
      sd_p   = sdout;
    end
  end

  // Directed stimulus.
  initial begin
    int rst_bad;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    fill = '{l: 24'h5A5A5A, r: 24'h5A5A5A};
`else
    fill = '{l: 24'h000000, r: 24'h000000};
`endif
    rst_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge mclk);
      if (sclk !== 1'b1 || lrclk !== 1'b1 || sdout !== 1'b0 || s_ready !== 1'b1 ||
          underrun !== 1'b0 || frame_start !== 1'b0) rst_bad++;
    end
    check("rst_sclk", {31'd0, sclk}, 32'd1);
    check("rst_lrclk", {31'd0, lrclk}, 32'd1);
    check("rst_sdout", {31'd0, sdout}, 32'd0);
    check("rst_ready", {31'd0, s_ready}, 32'd1);
    check("rst_quiet_cycles", rst_bad, 32'd0);
    #1 reset_n = 1'b1;

    exp_q.push_back('{l: 24'h800001, r: 24'h7FFFFE});
    push_pair(24'h800001, 24'h7FFFFE);
    idle();
    wait_boundary("b0");
    check("underrun_first_load", {31'd0, underrun}, 32'd0);

    exp_q.push_back('{l: 24'h000001, r: 24'hFFFFFE});
    exp_q.push_back('{l: 24'h123456, r: 24'hEDCBA9});
    exp_q.push_back('{l: 24'hFFFFFF, r: 24'h000000});
    push_pair(24'h000001, 24'hFFFFFE);
    check("ready_low_full", {31'd0, s_ready}, 32'd0);
    push_pair(24'h123456, 24'hEDCBA9);
    check("ready_low_full_b", {31'd0, s_ready}, 32'd0);
    push_pair(24'hFFFFFF, 24'h000000);

    exp_q.push_back('{l: 24'h5A5A5A, r: 24'h5A5A5A});
    push_pair(24'h5A5A5A, 24'h5A5A5A);
    idle();
    wait_boundary("b4");
    check("underrun_clean_load", {31'd0, underrun}, 32'd0);
    exp_q.push_back(fill);
    exp_q.push_back(fill);
    wait_boundary("b5");
    check("underrun_set", {31'd0, underrun}, 32'd1);

    repeat (100) @(negedge mclk);
    underrun_clr = 1'b1;
    @(negedge mclk);
    underrun_clr = 1'b0;
    check("underrun_clr", {31'd0, underrun}, 32'd0);
    repeat (410) @(negedge mclk);
    underrun_clr = 1'b1;
    @(negedge mclk);
    underrun_clr = 1'b0;
    check("frame_start_512", {31'd0, frame_start}, 32'd1);
    check("set_beats_clr", {31'd0, underrun}, 32'd1);

    exp_q.push_back(fill);
    exp_q.push_back('{l: 24'hA5C3E1, r: 24'h1E3C5A});
    repeat (100) @(negedge mclk);
    underrun_clr = 1'b1;
    @(negedge mclk);
    underrun_clr = 1'b0;
    repeat (410) @(negedge mclk);
    s_valid = 1'b1;
    s_left  = 24'hA5C3E1;
    s_right = 24'h1E3C5A;
    check("ready_before_load", {31'd0, s_ready}, 32'd1);
    @(negedge mclk);
    idle();
    check("load_accept_fs", {31'd0, frame_start}, 32'd1);
    check("load_accept_underrun", {31'd0, underrun}, 32'd1);
    check("load_accept_buffered", {31'd0, s_ready}, 32'd0);
    repeat (100) @(negedge mclk);
    underrun_clr = 1'b1;
    @(negedge mclk);
    underrun_clr = 1'b0;
    wait_boundary("b8");
    check("underrun_after_d", {31'd0, underrun}, 32'd0);
    wait_boundary("b9");
    check("underrun_b9", {31'd0, underrun}, 32'd1);

    push_pair(24'h111111, 24'h222222);
    idle();
    repeat (82) @(negedge mclk);
    check("pre_reset_lrclk", {31'd0, lrclk}, 32'd0);
    check("pre_reset_full", {31'd0, s_ready}, 32'd0);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_sclk", {31'd0, sclk}, 32'd1);
    check("midrst_lrclk", {31'd0, lrclk}, 32'd1);
    check("midrst_sdout", {31'd0, sdout}, 32'd0);
    check("midrst_ready", {31'd0, s_ready}, 32'd1);
    check("midrst_underrun", {31'd0, underrun}, 32'd0);
    repeat (3) @(negedge mclk);
    #1 reset_n = 1'b1;

    exp_q.push_back('{l: 24'h0F0F0F, r: 24'hF0F0F0});
    push_pair(24'h0F0F0F, 24'hF0F0F0);
    idle();
    wait_boundary("r0");
    check("underrun_after_rst", {31'd0, underrun}, 32'd0);
    wait_boundary("r1");
    repeat (4) @(negedge mclk);
    check("frames_left_in_queue", exp_q.size(), 32'd0);
    check("timing_violations", tim_bad, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
